// File: rtl/lcd_char_render_pkg.sv
// Shared constants, types and elaboration helpers for the multi-window character renderer.
package lcd_char_pkg;
    localparam int LCD_CHAR_LAT = 3;

    localparam logic [15:0] RGB_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;

    typedef struct packed {
        logic [15:0] fg;
        logic [15:0] bg;
    } colour_pair_t;

    localparam colour_pair_t COL_RESET = '{fg: RGB_WHITE, bg: RGB_BLACK};

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/lcd_char_render_if.sv
// Configuration and character-RAM write bus driven by the host side of the renderer.
interface lcd_char_render_if #(
    parameter int COORD_W = 11,
    parameter int WIN_W   = 1,
    parameter int IDX_W   = 3
);
    import lcd_char_pkg::*;

    logic               cfg_we;
    logic [WIN_W-1:0]   cfg_win;
    logic               cfg_en;
    logic [COORD_W-1:0] cfg_x;
    logic [COORD_W-1:0] cfg_y;
    logic [15:0]        cfg_fg;
    logic [15:0]        cfg_bg;

    logic               str_we;
    logic [WIN_W-1:0]   str_win;
    logic [IDX_W-1:0]   str_idx;
    logic [7:0]         str_code;

    modport master (
        output cfg_we, cfg_win, cfg_en, cfg_x, cfg_y, cfg_fg, cfg_bg,
        output str_we, str_win, str_idx, str_code
    );

    modport slave (
        input cfg_we, cfg_win, cfg_en, cfg_x, cfg_y, cfg_fg, cfg_bg,
        input str_we, str_win, str_idx, str_code
    );
endinterface

// File: rtl/lcd_char_render_win_hit.sv
// One text window: shadow/active config registers, extent test and glyph-relative offsets.
module lcd_char_win_hit
    import lcd_char_pkg::*;
#(
    parameter int COORD_W   = 11,
    parameter int CHAR_W    = 16,
    parameter int CHAR_H    = 32,
    parameter int NUM_CHARS = 8,
    parameter int OFF_W     = clog2(NUM_CHARS * CHAR_W),
    parameter int ROW_W     = clog2(CHAR_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               cfg_we,
    input  logic               cfg_en,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  colour_pair_t       cfg_col,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               hit,
    output logic [OFF_W-1:0]   off_x,
    output logic [ROW_W-1:0]   row,
    output colour_pair_t       col
);
    localparam logic [COORD_W:0] SPAN_X = (COORD_W+1)'(NUM_CHARS * CHAR_W);
    localparam logic [COORD_W:0] SPAN_Y = (COORD_W+1)'(CHAR_H);

    logic               sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    colour_pair_t       sh_col_q, sh_col_d, act_col_q, act_col_d;

    logic [COORD_W:0] px, py, x_lo, y_lo;

    // Active copy samples the shadow before any same-cycle write lands in it.
    always_comb begin
        sh_en_d   = sh_en_q;
        sh_x_d    = sh_x_q;
        sh_y_d    = sh_y_q;
        sh_col_d  = sh_col_q;
        act_en_d  = act_en_q;
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        act_col_d = act_col_q;
        if (cfg_we) begin
            sh_en_d  = cfg_en;
            sh_x_d   = cfg_x;
            sh_y_d   = cfg_y;
            sh_col_d = cfg_col;
        end
        if (frame_start) begin
            act_en_d  = sh_en_q;
            act_x_d   = sh_x_q;
            act_y_d   = sh_y_q;
            act_col_d = sh_col_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en_q   <= 1'b0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_col_q  <= COL_RESET;
            act_en_q  <= 1'b0;
            act_x_q   <= '0;
            act_y_q   <= '0;
            act_col_q <= COL_RESET;
        end else begin
            sh_en_q   <= sh_en_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            sh_col_q  <= sh_col_d;
            act_en_q  <= act_en_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            act_col_q <= act_col_d;
        end
    end

    // One extra bit keeps a window near the far edge from wrapping onto column/row 0.
    assign px   = {1'b0, pix_x};
    assign py   = {1'b0, pix_y};
    assign x_lo = {1'b0, act_x_q};
    assign y_lo = {1'b0, act_y_q};

    assign hit = act_en_q
              && (px >= x_lo) && (px < x_lo + SPAN_X)
              && (py >= y_lo) && (py < y_lo + SPAN_Y);

    assign off_x = pix_x[OFF_W-1:0] - act_x_q[OFF_W-1:0];
    assign row   = pix_y[ROW_W-1:0] - act_y_q[ROW_W-1:0];
    assign col   = act_col_q;
endmodule

// File: rtl/lcd_char_render.sv
// Multi-window text overlay: priority-selects the hit window, looks up the glyph code
// and font row, and emits RGB565 a fixed three cycles after each pixel request.
module lcd_char_render
    import lcd_char_pkg::*;
#(
    parameter int          CHAR_W    = 16,
    parameter int          CHAR_H    = 32,
    parameter int          NUM_CHARS = 8,
    parameter int          NUM_WIN   = 2,
    parameter int          COORD_W   = 11,
    parameter logic [15:0] BG_COLOR  = 16'hFFFF
) (
    input  logic                         lcd_pclk,
    input  logic                         rst_n,
    input  logic                         pixel_req,
    input  logic [COORD_W-1:0]           pixel_xpos,
    input  logic [COORD_W-1:0]           pixel_ypos,
    lcd_char_render_if.slave             cfg_bus,
    output logic [8+clog2(CHAR_H)-1:0]   font_addr,
    input  logic [CHAR_W-1:0]            font_row,
    output logic [15:0]                  pixel_data
);
    localparam int WIN_W  = (NUM_WIN > 1) ? clog2(NUM_WIN) : 1;
    localparam int IDX_W  = clog2(NUM_CHARS);
    localparam int BIT_W  = clog2(CHAR_W);
    localparam int ROW_W  = clog2(CHAR_H);
    localparam int OFF_W  = IDX_W + BIT_W;
    localparam int ADDR_W = WIN_W + IDX_W;
    localparam int VLD_N  = LCD_CHAR_LAT - 1;

    if (!is_pow2(CHAR_W) || CHAR_W < 8 || CHAR_W > 32) begin : g_bad_char_w
        $error("lcd_char_render: CHAR_W must be a power of two in 8..32");
    end
    if (!is_pow2(CHAR_H) || !is_pow2(NUM_CHARS) || NUM_CHARS < 2) begin : g_bad_geom
        $error("lcd_char_render: CHAR_H and NUM_CHARS must be powers of two");
    end
    if (NUM_WIN < 1 || NUM_WIN > 8 || OFF_W > COORD_W) begin : g_bad_win
        $error("lcd_char_render: NUM_WIN out of range or window wider than coordinate");
    end

    logic frame_start;
    assign frame_start = pixel_req && (pixel_xpos == '0) && (pixel_ypos == '0);

    logic [NUM_WIN-1:0]            win_hit;
    logic [NUM_WIN-1:0][OFF_W-1:0] win_off;
    logic [NUM_WIN-1:0][ROW_W-1:0] win_row;
    colour_pair_t [NUM_WIN-1:0]    win_col;
    colour_pair_t                  cfg_col;

    assign cfg_col = '{fg: cfg_bus.cfg_fg, bg: cfg_bus.cfg_bg};

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        lcd_char_win_hit #(
            .COORD_W   (COORD_W),
            .CHAR_W    (CHAR_W),
            .CHAR_H    (CHAR_H),
            .NUM_CHARS (NUM_CHARS),
            .OFF_W     (OFF_W),
            .ROW_W     (ROW_W)
        ) u_hit (
            .clk         (lcd_pclk),
            .rst_n       (rst_n),
            .frame_start (frame_start),
            .cfg_we      (cfg_bus.cfg_we && (cfg_bus.cfg_win == WIN_W'(w))),
            .cfg_en      (cfg_bus.cfg_en),
            .cfg_x       (cfg_bus.cfg_x),
            .cfg_y       (cfg_bus.cfg_y),
            .cfg_col     (cfg_col),
            .pix_x       (pixel_xpos),
            .pix_y       (pixel_ypos),
            .hit         (win_hit[w]),
            .off_x       (win_off[w]),
            .row         (win_row[w]),
            .col         (win_col[w])
        );
    end

    // Descending scan so the lowest-index hit is the last assignment and wins.
    logic             any_hit;
    logic [WIN_W-1:0] sel;
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if (win_hit[w]) begin
                any_hit = 1'b1;
                sel     = WIN_W'(w);
            end
        end
    end

    // Character RAM: no reset, read-before-write on address collision.
    logic [7:0]        char_ram [2**ADDR_W];
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = {sel, win_off[sel][OFF_W-1:BIT_W]};

    always_ff @(posedge lcd_pclk) begin
        if (cfg_bus.str_we) char_ram[{cfg_bus.str_win, cfg_bus.str_idx}] <= cfg_bus.str_code;
    end

    logic [VLD_N-1:0] vld_q, vld_d;
    logic             hit1_q, hit1_d, hit2_q, hit2_d;
    logic [BIT_W-1:0] bit1_q, bit1_d, bit2_q, bit2_d;
    logic [ROW_W-1:0] row1_q, row1_d;
    logic [7:0]       code1_q, code1_d;
    colour_pair_t     col1_q, col1_d, col2_q, col2_d;
    logic [15:0]      pixel_q, pixel_d;

    always_comb begin
        vld_d   = {vld_q[VLD_N-2:0], pixel_req};
        hit1_d  = pixel_req && any_hit;
        bit1_d  = win_off[sel][BIT_W-1:0];
        row1_d  = win_row[sel];
        col1_d  = win_col[sel];
        code1_d = char_ram[rd_addr];
        hit2_d  = hit1_q;
        bit2_d  = bit1_q;
        col2_d  = col1_q;
        pixel_d = RGB_BLACK;
        // MSB of the font row is the leftmost pixel, so bit b sits at index ~b.
        if (vld_q[VLD_N-1]) begin
            if (!hit2_q)               pixel_d = BG_COLOR;
            else if (font_row[~bit2_q]) pixel_d = col2_q.fg;
            else                       pixel_d = col2_q.bg;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            bit1_q  <= '0;
            bit2_q  <= '0;
            row1_q  <= '0;
            code1_q <= '0;
            col1_q  <= COL_RESET;
            col2_q  <= COL_RESET;
            pixel_q <= RGB_BLACK;
        end else begin
            vld_q   <= vld_d;
            hit1_q  <= hit1_d;
            hit2_q  <= hit2_d;
            bit1_q  <= bit1_d;
            bit2_q  <= bit2_d;
            row1_q  <= row1_d;
            code1_q <= code1_d;
            col1_q  <= col1_d;
            col2_q  <= col2_d;
            pixel_q <= pixel_d;
        end
    end

    assign font_addr  = {code1_q, row1_q};
    assign pixel_data = pixel_q;
endmodule

// File: tb/tb_lcd_char_render.sv
// Directed bench for lcd_char_render with default geometry and a one-glyph font model.
module tb_lcd_char_render;
    import lcd_char_pkg::*;

    logic        lcd_pclk   = 1'b0;
    logic        rst_n      = 1'b1;
    logic        pixel_req  = 1'b0;
    logic [10:0] pixel_xpos = '0;
    logic [10:0] pixel_ypos = '0;
    logic [12:0] font_addr;
    logic [15:0] font_row   = '0;
    logic [15:0] pixel_data;

    int n_assert = 0;
    int n_fail   = 0;

    lcd_char_render_if #(.COORD_W(11), .WIN_W(1), .IDX_W(3)) bus ();

    lcd_char_render #(
        .CHAR_W(16), .CHAR_H(32), .NUM_CHARS(8), .NUM_WIN(2), .COORD_W(11), .BG_COLOR(16'hFFFF)
    ) dut (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .pixel_req  (pixel_req),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .cfg_bus    (bus),
        .font_addr  (font_addr),
        .font_row   (font_row),
        .pixel_data (pixel_data)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    always @(posedge lcd_pclk)
        font_row <= (font_addr == 13'h820) ? 16'h8000 : 16'h0000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic w, input logic en, input logic [10:0] x, input logic [10:0] y,
                       input logic [15:0] fg, input logic [15:0] bg);
        @(negedge lcd_pclk);
        bus.cfg_we = 1'b1; bus.cfg_win = w; bus.cfg_en = en;
        bus.cfg_x = x; bus.cfg_y = y; bus.cfg_fg = fg; bus.cfg_bg = bg;
        @(negedge lcd_pclk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic str(input logic w, input logic [2:0] idx, input logic [7:0] code);
        @(negedge lcd_pclk);
        bus.str_we = 1'b1; bus.str_win = w; bus.str_idx = idx; bus.str_code = code;
        @(negedge lcd_pclk);
        bus.str_we = 1'b0;
    endtask

    // One request; font_addr checked at t+1 when fa >= 0, pixel_data at t+3.
    task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic [15:0] exp,
                       input int fa, input string tag);
        @(negedge lcd_pclk);
        pixel_req = 1'b1; pixel_xpos = x; pixel_ypos = y;
        @(negedge lcd_pclk);
        pixel_req = 1'b0;
        if (fa >= 0) check({tag, "_fa"}, 16'(font_addr), 16'(fa));
        @(negedge lcd_pclk);
        @(negedge lcd_pclk);
        check(tag, pixel_data, exp);
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_win = '0; bus.cfg_en = 1'b0; bus.cfg_x = '0; bus.cfg_y = '0;
        bus.cfg_fg = '0; bus.cfg_bg = '0;
        bus.str_we = 1'b0; bus.str_win = '0; bus.str_idx = '0; bus.str_code = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_pixel", pixel_data, 16'h0000);
        check("rst_faddr", 16'(font_addr), 16'h0000);
        repeat (3) @(negedge lcd_pclk);
        rst_n = 1'b1;

        // Disabled windows
        pix(11'd10, 11'd10, 16'hFFFF, -1, "dis_bg");
        @(negedge lcd_pclk);
        pixel_xpos = 11'd10; pixel_ypos = 11'd10;
        repeat (3) @(negedge lcd_pclk);
        check("noreq", pixel_data, 16'h0000);

        // Basic render
        cfg(1'b0, 1'b1, 11'd100, 11'd50, 16'hF800, 16'h001F);
        str(1'b0, 3'd0, 8'h41);
        str(1'b0, 3'd7, 8'h20);
        str(1'b0, 3'd2, 8'h20);
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs0");
        pix(11'd100, 11'd50, 16'hF800, 'h820, "basic_fg");
        pix(11'd101, 11'd50, 16'h001F, 'h820, "basic_bg");
        pix(11'd227, 11'd50, 16'h001F, 'h400, "last_col");
        pix(11'd228, 11'd50, 16'hFFFF, -1, "past_right");
        pix(11'd100, 11'd81, 16'h001F, 'h83F, "last_row");
        pix(11'd100, 11'd82, 16'hFFFF, -1, "past_bottom");
        pix(11'd99, 11'd50, 16'hFFFF, -1, "before_left");

        // Overlap priority
        cfg(1'b1, 1'b1, 11'd100, 11'd50, 16'h07E0, 16'h0000);
        str(1'b1, 3'd0, 8'h41);
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs1");
        pix(11'd100, 11'd50, 16'hF800, -1, "prio_w0");
        cfg(1'b0, 1'b0, 11'd100, 11'd50, 16'hF800, 16'h001F);
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs2");
        pix(11'd100, 11'd50, 16'h07E0, -1, "prio_w1_fg");
        pix(11'd101, 11'd50, 16'h0000, -1, "prio_w1_bg");

        // Right edge, no wrap
        cfg(1'b1, 1'b0, 11'd100, 11'd50, 16'h07E0, 16'h0000);
        cfg(1'b0, 1'b1, 11'd2000, 11'd50, 16'hF800, 16'h001F);
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs3");
        pix(11'd2047, 11'd50, 16'h001F, 'h400, "edge_hit");
        pix(11'd1999, 11'd50, 16'hFFFF, -1, "edge_left");
        pix(11'd0, 11'd50, 16'hFFFF, -1, "nowrap0");
        pix(11'd10, 11'd50, 16'hFFFF, -1, "nowrap10");

        // Mid-frame config write waits for frame start
        cfg(1'b0, 1'b1, 11'd100, 11'd50, 16'hF800, 16'h001F);
        pix(11'd2047, 11'd50, 16'h001F, -1, "cfg_hold_old");
        pix(11'd100, 11'd50, 16'hFFFF, -1, "cfg_hold_new");
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs4");
        pix(11'd100, 11'd50, 16'hF800, -1, "cfg_applied");

        // Write coincident with frame start lands one frame later
        @(negedge lcd_pclk);
        pixel_req = 1'b1; pixel_xpos = 11'd0; pixel_ypos = 11'd0;
        bus.cfg_we = 1'b1; bus.cfg_win = 1'b0; bus.cfg_en = 1'b1;
        bus.cfg_x = 11'd2000; bus.cfg_y = 11'd50; bus.cfg_fg = 16'hF800; bus.cfg_bg = 16'h001F;
        @(negedge lcd_pclk);
        pixel_req = 1'b0; bus.cfg_we = 1'b0;
        pix(11'd100, 11'd50, 16'hF800, -1, "coinc_old");
        pix(11'd2047, 11'd50, 16'hFFFF, -1, "coinc_not_yet");
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs5");
        pix(11'd100, 11'd50, 16'hFFFF, -1, "coinc_moved");
        pix(11'd2047, 11'd50, 16'h001F, -1, "coinc_new");

        // Reset mid-line
        @(negedge lcd_pclk);
        pixel_req = 1'b1; pixel_xpos = 11'd2047; pixel_ypos = 11'd50;
        repeat (3) @(negedge lcd_pclk);
        check("pre_rst", pixel_data, 16'h001F);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pixel", pixel_data, 16'h0000);
        check("async_rst_faddr", 16'(font_addr), 16'h0000);
        pixel_req = 1'b0;
        @(negedge lcd_pclk);
        rst_n = 1'b1;
        @(negedge lcd_pclk);
        pixel_req = 1'b1; pixel_xpos = 11'd2047; pixel_ypos = 11'd50;
        @(negedge lcd_pclk);
        pixel_req = 1'b0;
        check("post_rst_t1", pixel_data, 16'h0000);
        @(negedge lcd_pclk);
        check("post_rst_t2", pixel_data, 16'h0000);
        @(negedge lcd_pclk);
        check("post_rst_t3", pixel_data, 16'hFFFF);
        pix(11'd0, 11'd0, 16'hFFFF, -1, "fs6");
        pix(11'd2047, 11'd50, 16'hFFFF, -1, "post_rst_disabled");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
